// File: rtl/trsq_irq_ctrl.sv
// trsq_irq_ctrl: NUM_IRQ-source interrupt controller with sync, edge/level pending, masking and ack/EOI handshake.
// Optional round-robin priority when TRSQ_IRQ_ROTATE_PRIO_EN is defined.
module trsq_irq_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int SYNC_STAGES = 2,
  parameter int VEC_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [1:0]         reg_addr,
  input  logic               reg_wr,
  input  logic [7:0]         reg_wdata,
  output logic [7:0]         reg_rdata,
  output logic               irq_out,
  output logic [VEC_W-1:0]   irq_vec,
  input  logic               irq_ack
);
  typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_t;
  state_t state, state_n;
  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] s, s_d, enable, mode, pending, pending_n, cand, w1c, ack_clr;
  logic [VEC_W-1:0] sel, vec_n;
  logic out_n, ack_ok, eoi;
  logic [7:0] status;
  assign s = sync_q[SYNC_STAGES-1];
  assign ack_ok = state == REQ && irq_ack;
  assign eoi = state == ACTIVE && reg_wr && reg_addr == 2'd3;
  assign w1c = (reg_wr && reg_addr == 2'd1) ? reg_wdata[NUM_IRQ-1:0] : '0;
  assign ack_clr = ack_ok ? NUM_IRQ'(1) << irq_vec : '0;
  // Level sources mirror s; edge sources latch rising edges, and a set beats a clear.
  assign pending_n = (~mode & s) | (mode & ((pending & ~(w1c | ack_clr)) | (s & ~s_d)));
  assign cand = pending & enable;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_d <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_d <= s;
    end
  end
`ifdef TRSQ_IRQ_ROTATE_PRIO_EN
  logic [2:0] ptr, ptr_n;
  logic [2*NUM_IRQ-1:0] dbl;
  // Rotate candidates so the pointer sits at bit 0, then pick the lowest set bit.
  assign dbl = {cand, cand} >> ptr;
  always_comb begin
    int idx;
    int nxt;
    sel = '0;
    idx = 0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        idx = int'(ptr) + i;
        idx = idx >= NUM_IRQ ? idx - NUM_IRQ : idx;
        sel = VEC_W'(idx);
      end
    end
    nxt = int'(irq_vec) + 1;
    ptr_n = ack_ok ? (nxt >= NUM_IRQ ? 3'd0 : 3'(nxt)) : ptr;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr <= '0;
    else ptr <= ptr_n;
  end
`else
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (cand[i]) sel = VEC_W'(i);
  end
`endif
  always_comb begin
    state_n = state;
    out_n = irq_out;
    vec_n = irq_vec;
    case (state)
      IDLE: if (|cand) begin
        state_n = REQ;
        out_n = 1'b1;
        vec_n = sel;
      end
      REQ: if (irq_ack) begin
        state_n = ACTIVE;
        out_n = 1'b0;
      end
      ACTIVE: state_n = eoi ? IDLE : ACTIVE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    status = '0;
    status[7] = state == ACTIVE;
    status[6] = irq_out;
`ifdef TRSQ_IRQ_ROTATE_PRIO_EN
    status[5:3] = ptr;
`endif
    status[VEC_W-1:0] = irq_vec;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      irq_out <= 1'b0;
      irq_vec <= '0;
      enable <= '0;
      mode <= '0;
      pending <= '0;
      reg_rdata <= '0;
    end else begin
      state <= state_n;
      irq_out <= out_n;
      irq_vec <= vec_n;
      enable <= (reg_wr && reg_addr == 2'd0) ? reg_wdata[NUM_IRQ-1:0] : enable;
      mode <= (reg_wr && reg_addr == 2'd2) ? reg_wdata[NUM_IRQ-1:0] : mode;
      pending <= pending_n;
      reg_rdata <= reg_addr == 2'd0 ? 8'(enable) :
                   reg_addr == 2'd1 ? 8'(pending) :
                   reg_addr == 2'd2 ? 8'(mode) : status;
    end
  end
endmodule

// File: tb/tb_trsq_irq_ctrl.sv
// tb_trsq_irq_ctrl: table-driven register checks plus scripted interrupt sequences, scored through a queue.
module tb_trsq_irq_ctrl;
  logic clk = 0, reset = 1, reg_wr = 0, irq_ack = 0, irq_out;
  logic [7:0] irq_in = 0, reg_wdata = 0, reg_rdata;
  logic [1:0] reg_addr = 0;
  logic [2:0] irq_vec;
  int total = 0, bad = 0;
  typedef struct {string nm; logic [7:0] exp;} sb_t;
  typedef struct {logic wr; logic [1:0] a; logic [7:0] d; logic [7:0] exp; string nm;} vec_t;
  sb_t sb[$];
  vec_t tbl[13];
`ifdef TRSQ_IRQ_ROTATE_PRIO_EN
  localparam bit ROT = 1;
`else
  localparam bit ROT = 0;
`endif
  trsq_irq_ctrl dut (.clk(clk), .reset(reset), .irq_in(irq_in), .reg_addr(reg_addr), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .irq_out(irq_out), .irq_vec(irq_vec), .irq_ack(irq_ack));
  always #5 clk = ~clk;
  task automatic push(string nm, logic [7:0] e);
    sb.push_back('{nm, e});
  endtask
  task automatic check(logic [7:0] got);
    sb_t t;
    t = sb.pop_front();
    total++;
    if (got !== t.exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", t.nm, got, t.exp);
    end
  endtask
  task automatic chk_irq(string nm, logic o, logic [2:0] v);
    push(nm, {o, 4'b0, v});
    check({irq_out, 4'b0, irq_vec});
  endtask
  task automatic rd(logic [1:0] a, logic [7:0] e, string nm);
    @(negedge clk) reg_addr = a;
    push(nm, e);
    @(posedge clk) #1 check(reg_rdata);
  endtask
  task automatic wr(logic [1:0] a, logic [7:0] d);
    @(negedge clk) begin reg_addr = a; reg_wdata = d; reg_wr = 1; end
    @(negedge clk) reg_wr = 0;
  endtask
  task automatic ack();
    @(negedge clk) irq_ack = 1;
    @(negedge clk) irq_ack = 0;
  endtask
  task automatic pulse(logic [7:0] v);
    @(negedge clk) irq_in = v;
    @(negedge clk) irq_in = 0;
  endtask
  task automatic do_reset();
    irq_in = 0; irq_ack = 0; reg_wr = 0; reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
  endtask
  task automatic wait_irq(string nm);
    bit seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk) #1 seen = irq_out;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s got=timeout exp=irq_out", nm);
    end
  endtask
  task automatic apply(int i);
    if (tbl[i].wr) wr(tbl[i].a, tbl[i].d);
    else rd(tbl[i].a, tbl[i].exp, tbl[i].nm);
  endtask
  initial begin
    tbl[0] = '{0, 2'd0, 8'h00, 8'h00, "rst_enable"};
    tbl[1] = '{0, 2'd1, 8'h00, 8'h00, "rst_pending"};
    tbl[2] = '{0, 2'd2, 8'h00, 8'h00, "rst_mode"};
    tbl[3] = '{0, 2'd3, 8'h00, 8'h00, "rst_status"};
    tbl[4] = '{1, 2'd0, 8'hA5, 8'h00, "wr_en"};
    tbl[5] = '{0, 2'd0, 8'h00, 8'hA5, "rb_en"};
    tbl[6] = '{1, 2'd2, 8'h3C, 8'h00, "wr_mode"};
    tbl[7] = '{0, 2'd2, 8'h00, 8'h3C, "rb_mode"};
    tbl[8] = '{1, 2'd1, 8'hFF, 8'h00, "w1c_empty"};
    tbl[9] = '{0, 2'd1, 8'h00, 8'h00, "rb_pending"};
    tbl[10] = '{1, 2'd0, 8'h00, 8'h00, "wr_en0"};
    tbl[11] = '{0, 2'd0, 8'h00, 8'h00, "rb_en0"};
    tbl[12] = '{0, 2'd3, 8'h00, 8'h00, "rb_status"};
    do_reset();
    chk_irq("rst_irq", 0, 0);
    for (int i = 0; i < 13; i++) apply(i);
    // single edge pulse latency and ack/EOI
    do_reset();
    wr(0, 8'h01); wr(2, 8'h01);
    pulse(8'h01);
    repeat (2) @(posedge clk);
    #1 chk_irq("t1_before", 0, 0);
    @(posedge clk) #1 chk_irq("t1_raise", 1, 0);
    ack();
    chk_irq("t1_ack_drop", 0, 0);
    rd(1, 8'h00, "t1_pend_clr");
    rd(3, ROT ? 8'h88 : 8'h80, "t1_active");
    wr(3, 8'h00);
    rd(3, ROT ? 8'h08 : 8'h00, "t1_eoi");
    // priority between two simultaneous edges
    do_reset();
    wr(0, 8'hFF); wr(2, 8'hFF);
    @(negedge clk) irq_in = 8'h24;
    wait_irq("t2_wait1");
    chk_irq("t2_first", 1, 2);
    ack(); wr(3, 8'h00);
    @(posedge clk) #1 chk_irq("t2_next", 1, 5);
    ack(); irq_in = 0; wr(3, 8'h00);
    repeat (4) @(posedge clk);
    #1 chk_irq("t2_idle", 0, 5);
    @(negedge clk) irq_in = 8'h04;
    wait_irq("t2_wait2");
    ack(); wr(3, 8'h00);
    irq_in = 0;
    repeat (4) @(posedge clk);
    rd(3, ROT ? 8'h1A : 8'h02, "t2_ptr");
    @(negedge clk) irq_in = 8'h24;
    wait_irq("t2_wait3");
    chk_irq("t2_prio", 1, ROT ? 3'd5 : 3'd2);
    // level mode source 3
    do_reset();
    wr(0, 8'h08);
    @(negedge clk) irq_in = 8'h08;
    wait_irq("t3_wait");
    chk_irq("t3_raise", 1, 3);
    wr(1, 8'h08);
    rd(1, 8'h08, "t3_w1c_ignored");
    ack(); wr(3, 8'h00);
    @(posedge clk) #1 chk_irq("t3_reassert", 1, 3);
    ack();
    @(negedge clk) begin irq_in = 0; reg_addr = 1; end
    push("t3_pend_hold", 8'h08);
    repeat (3) @(posedge clk);
    #1 check(reg_rdata);
    push("t3_pend_drop", 8'h00);
    @(posedge clk) #1 check(reg_rdata);
    // masked source latches pending
    do_reset();
    wr(2, 8'h02);
    pulse(8'h02);
    repeat (4) @(posedge clk);
    rd(1, 8'h02, "t4_pending");
    chk_irq("t4_masked", 0, 0);
    wr(0, 8'h02);
    @(posedge clk) #1 chk_irq("t4_unmask", 1, 1);
    // REQ hold, EOI in REQ and stray acks ignored
    do_reset();
    wr(0, 8'h10); wr(2, 8'h10);
    pulse(8'h10);
    wait_irq("t5_wait");
    wr(0, 8'h00); wr(2, 8'h00);
    wr(3, 8'h00);
    chk_irq("t5_hold", 1, 4);
    rd(3, 8'h44, "t5_req_status");
    ack(); ack(); ack();
    chk_irq("t5_after_acks", 0, 4);
    rd(3, ROT ? 8'hAC : 8'h84, "t5_active");
    // async reset during REQ
    do_reset();
    wr(0, 8'h01); wr(2, 8'h01);
    pulse(8'h01);
    wait_irq("t6_wait");
    rd(0, 8'h01, "t6_en");
    #2 reset = 1;
    #1 chk_irq("t6_async_irq", 0, 0);
    push("t6_async_rdata", 8'h00);
    check(reg_rdata);
    @(negedge clk) reset = 0;
    for (int i = 0; i < 4; i++) apply(i);
    repeat (6) @(posedge clk);
    #1 chk_irq("t6_no_req", 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
